alu_rs_scheduler: RTL and testbench

ALU reservation station and issue scheduler for the out-of-order core. It accepts decoded ALU operations (operation, operand data or producer tags, destination ROB tag) from the decoder and holds them in an `ENTRIES`-deep station. It snoops the common data bus (CDB) to wake up operands and issues at most one ready operation per cycle to the single shared ALU. It sits between the decoder and the ALU and replaces the decoder's direct ALU write path.

---
 rtl/alu_rs_scheduler.sv | 174 +++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops, wakes operands from the CDB,
// and issues the lowest-index ready entry to the single ALU each cycle.
module alu_rs_scheduler #(
    parameter int unsigned      ENTRIES  = 8,
    parameter int unsigned      DATA_W   = 32,
    parameter int unsigned      TAG_W    = 4,
    parameter int unsigned      OP_W     = 6,
    parameter logic [TAG_W-1:0] TAG_FREE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [OP_W-1:0]           in_op,
    input  logic [TAG_W-1:0]          in_dest,
    input  logic [TAG_W-1:0]          in_tag1,
    input  logic [TAG_W-1:0]          in_tag2,
    input  logic [DATA_W-1:0]         in_data1,
    input  logic [DATA_W-1:0]         in_data2,
    output logic                      rs_full,
    output logic [$clog2(ENTRIES):0]  rs_count,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_tag,
    input  logic [DATA_W-1:0]         cdb_data,
    input  logic                      alu_ready,
    output logic                      alu_issue,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [TAG_W-1:0]          alu_dest,
    input  logic                      flush
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [OP_W-1:0]    op_q    [ENTRIES];
    logic [OP_W-1:0]    op_d    [ENTRIES];
    logic [TAG_W-1:0]   dest_q  [ENTRIES];
    logic [TAG_W-1:0]   dest_d  [ENTRIES];
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag1_d  [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_d  [ENTRIES];
    logic [DATA_W-1:0]  data1_q [ENTRIES];
    logic [DATA_W-1:0]  data1_d [ENTRIES];
    logic [DATA_W-1:0]  data2_q [ENTRIES];
    logic [DATA_W-1:0]  data2_d [ENTRIES];
    logic [CNT_W-1:0]   count_q, count_d;

    logic               alu_issue_q;
    logic [OP_W-1:0]    alu_op_q;
    logic [DATA_W-1:0]  alu_a_q, alu_b_q;
    logic [TAG_W-1:0]   alu_dest_q;

    logic               sel_found, alloc_found, issue, alloc;
    logic [IDX_W-1:0]   sel_idx, alloc_idx;
    logic [TAG_W-1:0]   new_tag1, new_tag2;
    logic [DATA_W-1:0]  new_data1, new_data2;

    assign rs_full   = (count_q == CNT_W'(ENTRIES));
    assign rs_count  = count_q;
    assign alu_issue = alu_issue_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_dest  = alu_dest_q;

    // Select and free-slot search look only at registered entry state.
    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = '0;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!sel_found && valid_q[i] && tag1_q[i] == TAG_FREE && tag2_q[i] == TAG_FREE) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!alloc_found && !valid_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
        issue = sel_found && alu_ready;
        alloc = in_valid && !rs_full;
    end

    // Dispatch bypass: an operand broadcast in the allocate cycle is captured directly.
    always_comb begin
        new_tag1  = in_tag1;
        new_data1 = in_data1;
        new_tag2  = in_tag2;
        new_data2 = in_data2;
        if (cdb_valid && in_tag1 != TAG_FREE && in_tag1 == cdb_tag) begin
            new_tag1  = TAG_FREE;
            new_data1 = cdb_data;
        end
        if (cdb_valid && in_tag2 != TAG_FREE && in_tag2 == cdb_tag) begin
            new_tag2  = TAG_FREE;
            new_data2 = cdb_data;
        end
    end

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        dest_d  = dest_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        count_d = count_q + CNT_W'(alloc) - CNT_W'(issue);
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && cdb_valid && tag1_q[i] != TAG_FREE && tag1_q[i] == cdb_tag) begin
                tag1_d[i]  = TAG_FREE;
                data1_d[i] = cdb_data;
            end
            if (valid_q[i] && cdb_valid && tag2_q[i] != TAG_FREE && tag2_q[i] == cdb_tag) begin
                tag2_d[i]  = TAG_FREE;
                data2_d[i] = cdb_data;
            end
        end
        if (issue) begin
            valid_d[sel_idx] = 1'b0;
        end
        // alloc_idx is an invalid slot, so it never collides with the issued one.
        if (alloc) begin
            valid_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]    = in_op;
            dest_d[alloc_idx]  = in_dest;
            tag1_d[alloc_idx]  = new_tag1;
            data1_d[alloc_idx] = new_data1;
            tag2_d[alloc_idx]  = new_tag2;
            data2_d[alloc_idx] = new_data2;
        end
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            count_q     <= '0;
            alu_issue_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_dest_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            alu_issue_q <= issue && !flush;
            if (issue && !flush) begin
                alu_op_q   <= op_q[sel_idx];
                alu_a_q    <= data1_q[sel_idx];
                alu_b_q    <= data2_q[sel_idx];
                alu_dest_q <= dest_q[sel_idx];
            end
        end
    end

    // Payload storage is qualified by the valid bits and needs no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        dest_q  <= dest_d;
        tag1_q  <= tag1_d;
        tag2_q  <= tag2_d;
        data1_q <= data1_d;
        data2_q <= data2_d;
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: a behavioural model checked every cycle
// plus hand-computed expectations at the key points of each scenario.
module tb_alu_rs_scheduler;
    logic        clk, rst, in_valid, cdb_valid, alu_ready, flush;
    logic [5:0]  in_op;
    logic [3:0]  in_dest, in_tag1, in_tag2, cdb_tag;
    logic [31:0] in_data1, in_data2, cdb_data;
    logic        rs_full, alu_issue;
    logic [3:0]  rs_count;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_dest;

    int nerr = 0;
    int nchk = 0;
    bit mon_en = 0;

    alu_rs_scheduler dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_dest(in_dest),
        .in_tag1(in_tag1), .in_tag2(in_tag2), .in_data1(in_data1), .in_data2(in_data2),
        .rs_full(rs_full), .rs_count(rs_count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .alu_ready(alu_ready), .alu_issue(alu_issue), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_dest(alu_dest), .flush(flush)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bag of 8 slots, oldest-index-first selection.
    typedef struct {
        bit          v;
        logic [5:0]  op;
        logic [3:0]  dest, t1, t2;
        logic [31:0] d1, d2;
    } ent_t;
    ent_t        m [8];
    logic        e_issue = 0;
    logic [5:0]  e_op = 0;
    logic [31:0] e_a = 0, e_b = 0;
    logic [3:0]  e_dest = 0;
    int          e_cnt = 0;
    int          s, f;

    always @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < 8; i++) m[i].v = 0;
            e_issue = 0;
            if (rst) begin e_op = 0; e_a = 0; e_b = 0; e_dest = 0; end
        end else begin
            s = -1; f = -1;
            for (int i = 0; i < 8; i++) begin
                if (s < 0 && m[i].v && m[i].t1 == 0 && m[i].t2 == 0) s = i;
                if (f < 0 && !m[i].v) f = i;
            end
            e_issue = (s >= 0) && alu_ready;
            if (e_issue) begin
                e_op = m[s].op; e_a = m[s].d1; e_b = m[s].d2; e_dest = m[s].dest;
                m[s].v = 0;
            end
            if (cdb_valid && cdb_tag != 0)
                for (int i = 0; i < 8; i++) begin
                    if (m[i].v && m[i].t1 == cdb_tag) begin m[i].t1 = 0; m[i].d1 = cdb_data; end
                    if (m[i].v && m[i].t2 == cdb_tag) begin m[i].t2 = 0; m[i].d2 = cdb_data; end
                end
            if (in_valid) begin
                if (f < 0) $display("note: protocol error, dispatch while full dropped at %0t", $time);
                else begin
                    m[f] = '{1, in_op, in_dest, in_tag1, in_tag2, in_data1, in_data2};
                    if (cdb_valid && in_tag1 != 0 && in_tag1 == cdb_tag) begin m[f].t1 = 0; m[f].d1 = cdb_data; end
                    if (cdb_valid && in_tag2 != 0 && in_tag2 == cdb_tag) begin m[f].t2 = 0; m[f].d2 = cdb_data; end
                end
            end
        end
        e_cnt = 0;
        for (int i = 0; i < 8; i++) e_cnt += int'(m[i].v);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("m_issue", 32'(alu_issue), 32'(e_issue));
            chk("m_op",    32'(alu_op),    32'(e_op));
            chk("m_a",     alu_a,          e_a);
            chk("m_b",     alu_b,          e_b);
            chk("m_dest",  32'(alu_dest),  32'(e_dest));
            chk("m_count", 32'(rs_count),  32'(e_cnt));
            chk("m_full",  32'(rs_full),   32'(e_cnt == 8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; cdb_valid = 0; flush = 0;
        in_op = 0; in_dest = 0; in_tag1 = 0; in_tag2 = 0;
        in_data1 = 0; in_data2 = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [3:0] dest, input logic [3:0] t1,
                        input logic [31:0] d1, input logic [3:0] t2, input logic [31:0] d2);
        in_valid = 1; in_op = op; in_dest = dest;
        in_tag1 = t1; in_data1 = d1; in_tag2 = t2; in_data2 = d2;
    endtask

    initial begin
        idle();
        rst = 1; alu_ready = 1;
        tick(); tick();
        mon_en = 1;
        chk("rst_count", 32'(rs_count), 0);
        chk("rst_issue", 32'(alu_issue), 0);
        chk("rst_full",  32'(rs_full), 0);
        rst = 0;

        // ADD with both operands free: issue 2 edges after dispatch
        disp(6'd1, 4'd3, 0, 32'd5, 0, 32'd7);
        tick(); idle();
        chk("add_cnt1", 32'(rs_count), 1);
        chk("add_noissue", 32'(alu_issue), 0);
        tick();
        chk("add_issue", 32'(alu_issue), 1);
        chk("add_a", alu_a, 5);
        chk("add_b", alu_b, 7);
        chk("add_dest", 32'(alu_dest), 3);
        chk("add_cnt0", 32'(rs_count), 0);
        tick();
        chk("add_once", 32'(alu_issue), 0);

        // SUB waiting on tag 6
        disp(6'd2, 4'd4, 4'd6, 32'd0, 0, 32'd2);
        tick(); idle();
        tick();
        chk("sub_wait", 32'(alu_issue), 0);
        cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 32'h10;
        tick(); idle();
        chk("sub_cdb_same", 32'(alu_issue), 0);
        tick();
        chk("sub_issue", 32'(alu_issue), 1);
        chk("sub_a", alu_a, 32'h10);

        // Dispatch bypass of tag 9
        disp(6'd3, 4'd5, 0, 32'd1, 4'd9, 32'd0);
        cdb_valid = 1; cdb_tag = 4'd9; cdb_data = 32'hAB;
        tick(); idle();
        tick();
        chk("byp_issue", 32'(alu_issue), 1);
        chk("byp_b", alu_b, 32'hAB);
        tick();

        // Fill with ALU stalled, overflow dispatch dropped, then drain in order
        alu_ready = 0;
        for (int i = 0; i < 8; i++) begin
            disp(6'd4, 4'(i + 1), 0, 32'(i * 10), 0, 32'd0);
            tick();
        end
        chk("fill_full", 32'(rs_full), 1);
        chk("fill_cnt", 32'(rs_count), 8);
        disp(6'd4, 4'd15, 0, 32'd99, 0, 32'd0);
        tick(); idle();
        chk("drop_cnt", 32'(rs_count), 8);
        chk("stall_hold", alu_b, 32'hAB);
        alu_ready = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("drain_issue", 32'(alu_issue), 1);
            chk("drain_dest", 32'(alu_dest), 32'(k + 1));
        end
        tick();
        chk("drain_done", 32'(alu_issue), 0);

        // Priority: entries 2 and 5 ready, 0 waits on tag 7, others on tag 8
        alu_ready = 0;
        disp(6'd5, 4'd10, 4'd7, 0, 0, 32'd1); tick();
        disp(6'd5, 4'd11, 4'd8, 0, 0, 32'd1); tick();
        disp(6'd5, 4'd2,  0, 32'd2, 0, 32'd1); tick();
        disp(6'd5, 4'd12, 4'd8, 0, 0, 32'd1); tick();
        disp(6'd5, 4'd13, 4'd8, 0, 0, 32'd1); tick();
        disp(6'd5, 4'd5,  0, 32'd5, 0, 32'd1); tick();
        idle(); alu_ready = 1;
        tick();
        chk("prio_first", 32'(alu_dest), 2);
        tick();
        chk("prio_second", 32'(alu_dest), 5);
        tick();
        chk("prio_wait", 32'(alu_issue), 0);
        cdb_valid = 1; cdb_tag = 4'd7; cdb_data = 32'h77;
        tick(); idle();
        tick();
        chk("prio_e0_issue", 32'(alu_issue), 1);
        chk("prio_e0_dest", 32'(alu_dest), 10);
        chk("prio_e0_a", alu_a, 32'h77);

        // Flush with 4 valid entries while allocating and broadcasting
        alu_ready = 0;
        disp(6'd6, 4'd14, 4'd8, 0, 0, 32'd3); tick();
        chk("fl_cnt4", 32'(rs_count), 4);
        flush = 1; alu_ready = 1;
        disp(6'd6, 4'd1, 0, 32'd1, 0, 32'd1);
        cdb_valid = 1; cdb_tag = 4'd8; cdb_data = 32'h88;
        tick(); idle();
        chk("fl_cnt0", 32'(rs_count), 0);
        chk("fl_issue", 32'(alu_issue), 0);
        tick(); tick();
        chk("fl_quiet", 32'(alu_issue), 0);

        // Same with reset: outputs all zero
        alu_ready = 0;
        for (int i = 0; i < 4; i++) begin
            disp(6'd7, 4'(i + 2), 0, 32'(i + 1), 0, 32'd9);
            tick();
        end
        chk("rs_cnt4", 32'(rs_count), 4);
        rst = 1; alu_ready = 1;
        disp(6'd7, 4'd9, 0, 32'd1, 0, 32'd1);
        cdb_valid = 1; cdb_tag = 4'd8; cdb_data = 32'h88;
        tick(); idle(); rst = 0;
        chk("rs_cnt0", 32'(rs_count), 0);
        chk("rs_issue0", 32'(alu_issue), 0);
        chk("rs_op0", 32'(alu_op), 0);
        chk("rs_a0", alu_a, 0);
        chk("rs_b0", alu_b, 0);
        chk("rs_dest0", 32'(alu_dest), 0);
        tick(); tick();
        chk("rs_quiet", 32'(alu_issue), 0);

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
